// File: rtl/wishbone_register_slave_if.sv
// Wishbone classic bus bundle between a host master and a register slave.
// Signals: i_wbs_cyc/stb/we/sel/adr/dat toward the slave; o_wbs_dat/ack/err back.
interface wishbone_register_slave_if;
    logic        i_wbs_cyc;
    logic        i_wbs_stb;
    logic        i_wbs_we;
    logic [3:0]  i_wbs_sel;
    logic [31:0] i_wbs_adr;
    logic [31:0] i_wbs_dat;
    logic [31:0] o_wbs_dat;
    logic        o_wbs_ack;
    logic        o_wbs_err;

    modport slave (
        input  i_wbs_cyc, i_wbs_stb, i_wbs_we,
        input  i_wbs_sel, i_wbs_adr, i_wbs_dat,
        output o_wbs_dat, o_wbs_ack, o_wbs_err
    );

    modport master (
        output i_wbs_cyc, i_wbs_stb, i_wbs_we,
        output i_wbs_sel, i_wbs_adr, i_wbs_dat,
        input  o_wbs_dat, o_wbs_ack, o_wbs_err
    );
endinterface

// File: rtl/wishbone_register_slave.sv
// Wishbone classic register-bank slave with configurable wait states.
// Ports: clk, rst (async, active-high), wbs (slave modport), o_wr_count.
// Define WB_SLAVE_ERR_EN to terminate out-of-range accesses with err.
module wishbone_register_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          REG_COUNT   = 16,
    parameter int          WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    wishbone_register_slave_if.slave wbs,
    output logic [15:0]           o_wr_count
);
    localparam int IW = $clog2(REG_COUNT);

`ifdef WB_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [IW-1:0]   idx_q;
    logic            hit_q;
    logic            we_q;
    logic [3:0]      sel_q;
    logic [31:0]     wdat_q;
    logic            ack_q;
    logic            err_q;
    logic [31:0]     rdat_q;
    logic [15:0]     wr_count_q;
    logic [31:0]     regs_q [1:REG_COUNT-1];

    // Address decode of the live bus request.
    logic [29:0]     word_d;
    logic            hit_d;
    logic [IW-1:0]   idx_d;

    assign word_d = 30'((wbs.i_wbs_adr - ADDR_BASE) >> 2);
    assign hit_d  = word_d < 30'(REG_COUNT);
    assign idx_d  = word_d[IW-1:0];

    // RESP is entered from IDLE (zero wait states) using the live decode,
    // or from WAIT using the latched one.
    logic            cur_hit;
    logic [IW-1:0]   cur_idx;
    logic            cur_we;
    logic            rsp_ack_d;
    logic            rsp_err_d;
    logic [31:0]     rsp_dat_d;

    always_comb begin
        cur_hit = hit_q;
        cur_idx = idx_q;
        cur_we  = we_q;
        if (state_q == S_IDLE) begin
            cur_hit = hit_d;
            cur_idx = idx_d;
            cur_we  = wbs.i_wbs_we;
        end
    end

    always_comb begin
        rsp_ack_d = cur_hit || !ERR_EN;
        rsp_err_d = !cur_hit && ERR_EN;
        rsp_dat_d = 32'h0;
        if (!cur_we && cur_hit) begin
            if (cur_idx == '0) begin
                rsp_dat_d = {8'(REG_COUNT), 4'(WAIT_STATES), 4'h0, wr_count_q};
            end else begin
                for (int j = 1; j < REG_COUNT; j++) begin
                    if (cur_idx == IW'(j)) begin
                        rsp_dat_d = regs_q[j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'h0;
            idx_q      <= '0;
            hit_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            wdat_q     <= 32'h0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdat_q     <= 32'h0;
            wr_count_q <= 16'h0;
            for (int j = 1; j < REG_COUNT; j++) begin
                regs_q[j] <= 32'h0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (wbs.i_wbs_cyc && wbs.i_wbs_stb && !ack_q && !err_q) begin
                        idx_q  <= idx_d;
                        hit_q  <= hit_d;
                        we_q   <= wbs.i_wbs_we;
                        sel_q  <= wbs.i_wbs_sel;
                        wdat_q <= wbs.i_wbs_dat;
                        if (WAIT_STATES == 0) begin
                            state_q <= S_RESP;
                            ack_q   <= rsp_ack_d;
                            err_q   <= rsp_err_d;
                            rdat_q  <= rsp_dat_d;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (!wbs.i_wbs_cyc) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == 4'h0) begin
                        state_q <= S_RESP;
                        ack_q   <= rsp_ack_d;
                        err_q   <= rsp_err_d;
                        rdat_q  <= rsp_dat_d;
                    end else begin
                        cnt_q <= cnt_q - 4'h1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdat_q  <= 32'h0;
                    // Index 0 is read-only; an empty sel changes nothing.
                    if (we_q && hit_q && idx_q != '0 && sel_q != 4'h0) begin
                        for (int j = 1; j < REG_COUNT; j++) begin
                            if (idx_q == IW'(j)) begin
                                for (int b = 0; b < 4; b++) begin
                                    if (sel_q[b]) begin
                                        regs_q[j][8*b +: 8] <= wdat_q[8*b +: 8];
                                    end
                                end
                            end
                        end
                        if (wr_count_q != 16'hFFFF) begin
                            wr_count_q <= wr_count_q + 16'h1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wbs.o_wbs_ack = ack_q;
    assign wbs.o_wbs_err = err_q;
    assign wbs.o_wbs_dat = rdat_q;
    assign o_wr_count    = wr_count_q;
endmodule

// File: tb/tb_wishbone_register_slave.sv
// Testbench for wishbone_register_slave: three instances with different
// wait states, bases and sizes, checked against a register-bank model.
module tb_wishbone_register_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic        m_cyc;
    logic        m_stb;
    logic        m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr;
    logic [31:0] m_dat;
    int          cur;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wishbone_register_slave_if wa ();
    wishbone_register_slave_if wb ();
    wishbone_register_slave_if wc ();

    logic [15:0] cnt_a, cnt_b, cnt_c;

    assign wa.i_wbs_cyc = m_cyc && cur == 0;
    assign wa.i_wbs_stb = m_stb && cur == 0;
    assign wa.i_wbs_we  = m_we;
    assign wa.i_wbs_sel = m_sel;
    assign wa.i_wbs_adr = m_adr;
    assign wa.i_wbs_dat = m_dat;
    assign wb.i_wbs_cyc = m_cyc && cur == 1;
    assign wb.i_wbs_stb = m_stb && cur == 1;
    assign wb.i_wbs_we  = m_we;
    assign wb.i_wbs_sel = m_sel;
    assign wb.i_wbs_adr = m_adr;
    assign wb.i_wbs_dat = m_dat;
    assign wc.i_wbs_cyc = m_cyc && cur == 2;
    assign wc.i_wbs_stb = m_stb && cur == 2;
    assign wc.i_wbs_we  = m_we;
    assign wc.i_wbs_sel = m_sel;
    assign wc.i_wbs_adr = m_adr;
    assign wc.i_wbs_dat = m_dat;

    wishbone_register_slave #(
        .ADDR_BASE(32'h0000_0000), .REG_COUNT(16), .WAIT_STATES(1)
    ) u_a (.clk(clk), .rst(rst), .wbs(wa.slave), .o_wr_count(cnt_a));

    wishbone_register_slave #(
        .ADDR_BASE(32'h0000_1000), .REG_COUNT(8), .WAIT_STATES(3)
    ) u_b (.clk(clk), .rst(rst), .wbs(wb.slave), .o_wr_count(cnt_b));

    wishbone_register_slave #(
        .ADDR_BASE(32'hFFFF_FFF8), .REG_COUNT(4), .WAIT_STATES(0)
    ) u_c (.clk(clk), .rst(rst), .wbs(wc.slave), .o_wr_count(cnt_c));

    logic        s_ack, s_err;
    logic [31:0] s_dat;
    logic [15:0] s_cnt;

    always_comb begin
        s_ack = wa.o_wbs_ack;
        s_err = wa.o_wbs_err;
        s_dat = wa.o_wbs_dat;
        s_cnt = cnt_a;
        if (cur == 1) begin
            s_ack = wb.o_wbs_ack;
            s_err = wb.o_wbs_err;
            s_dat = wb.o_wbs_dat;
            s_cnt = cnt_b;
        end else if (cur == 2) begin
            s_ack = wc.o_wbs_ack;
            s_err = wc.o_wbs_err;
            s_dat = wc.o_wbs_dat;
            s_cnt = cnt_c;
        end
    end

    // Reference model: per-instance register contents and write count.
    int          ws   [3] = '{1, 3, 0};
    int          rc   [3] = '{16, 8, 4};
    logic [31:0] base [3] = '{32'h0000_0000, 32'h0000_1000, 32'hFFFF_FFF8};
    logic [31:0] mem  [3][16];
    int          mcnt [3];

`ifdef WB_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            mcnt[d] = 0;
            for (int i = 0; i < 16; i++) mem[d][i] = 32'h0;
        end
    endtask

    function automatic logic [31:0] word_of(int d, logic [31:0] adr);
        return (adr - base[d]) >> 2;
    endfunction

    function automatic logic in_map(int d, logic [31:0] adr);
        return word_of(d, adr) < 32'(rc[d]);
    endfunction

    function automatic logic [31:0] exp_read(int d, logic [31:0] adr);
        logic [31:0] w;
        w = word_of(d, adr);
        if (!in_map(d, adr)) return 32'h0;
        if (w == 0) return {8'(rc[d]), 4'(ws[d]), 4'h0, 16'(mcnt[d])};
        return mem[d][w];
    endfunction

    task automatic model_write(int d, logic [3:0] sel,
                               logic [31:0] adr, logic [31:0] dat);
        logic [31:0] w;
        w = word_of(d, adr);
        if (in_map(d, adr) && w != 0 && sel != 4'h0) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) mem[d][w][8*b +: 8] = dat[8*b +: 8];
            if (mcnt[d] < 65535) mcnt[d]++;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transfer on instance d, checking latency and response.
    task automatic xfer(int d, logic we, logic [3:0] sel,
                        logic [31:0] adr, logic [31:0] dat);
        int          k;
        logic        h;
        logic [31:0] xd;
        @(negedge clk);
        cur   = d;
        m_cyc = 1'b1;
        m_stb = 1'b1;
        m_we  = we;
        m_sel = sel;
        m_adr = adr;
        m_dat = dat;
        h  = in_map(d, adr);
        xd = we ? 32'h0 : exp_read(d, adr);
        k  = 0;
        @(posedge clk);
        #1;
        while (!(s_ack || s_err) && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        m_cyc = 1'b0;
        m_stb = 1'b0;
        chk("latency", 32'(k), 32'(ws[d]));
        chk("ack", {31'h0, s_ack}, {31'h0, h || !ERR_EN});
        chk("err", {31'h0, s_err}, {31'h0, !h && ERR_EN});
        chk("rdata", s_dat, xd);
        if (we) model_write(d, sel, adr, dat);
        @(posedge clk);
        #1;
        chk("pulse", {30'h0, s_ack, s_err}, 32'h0);
        chk("dat_idle", s_dat, 32'h0);
        chk("wr_count", {16'h0, s_cnt}, 32'(mcnt[d]));
    endtask

    initial begin
        logic        seen;
        logic [31:0] a;
        cur   = 0;
        m_cyc = 1'b0;
        m_stb = 1'b0;
        m_we  = 1'b0;
        m_sel = 4'h0;
        m_adr = 32'h0;
        m_dat = 32'h0;
        rst   = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'h0, wa.o_wbs_ack}, 32'h0);
        chk("rst_dat", wa.o_wbs_dat, 32'h0);
        chk("rst_cnt", {16'h0, cnt_a}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ID register and partial-lane writes.
        xfer(0, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
        xfer(0, 1'b1, 4'hF, 32'h0000_000C, 32'hDEADBEEF);
        xfer(0, 1'b1, 4'h1, 32'h0000_000C, 32'h0000_00AA);
        xfer(0, 1'b0, 4'h0, 32'h0000_000C, 32'h0);
        chk("merge", mem[0][3], 32'hDEADBEAA);
        xfer(0, 1'b1, 4'hF, 32'h0000_0000, 32'h1234_5678);
        xfer(0, 1'b1, 4'h0, 32'h0000_0010, 32'h1234_5678);
        xfer(0, 1'b0, 4'hF, 32'h0000_0003, 32'h0);
        xfer(0, 1'b0, 4'hF, 32'h0000_0040, 32'h0);
        xfer(0, 1'b1, 4'hF, 32'h0000_0044, 32'h5555_5555);

        // Abort during wait states: cyc dropped, nothing must happen.
        xfer(1, 1'b1, 4'hF, 32'h0000_1008, 32'h0BAD_F00D);
        @(negedge clk);
        cur   = 1;
        m_cyc = 1'b1;
        m_stb = 1'b1;
        m_we  = 1'b1;
        m_sel = 4'hF;
        m_adr = 32'h0000_1008;
        m_dat = 32'hFFFF_FFFF;
        @(posedge clk);
        @(posedge clk);
        #1;
        m_cyc = 1'b0;
        m_stb = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            seen = seen | s_ack | s_err;
        end
        chk("abort_term", {31'h0, seen}, 32'h0);
        xfer(1, 1'b0, 4'hF, 32'h0000_1008, 32'h0);
        xfer(1, 1'b0, 4'hF, 32'h0000_1000, 32'h0);
        xfer(1, 1'b0, 4'hF, 32'h0000_1020, 32'h0);

        // Back-to-back with cyc/stb held and no wait states.
        @(negedge clk);
        cur   = 2;
        m_cyc = 1'b1;
        m_stb = 1'b1;
        m_we  = 1'b1;
        m_sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            m_adr = 32'hFFFF_FFFC + 32'(4 * (i % 3));
            m_dat = 32'hA000_0000 + 32'(i);
            @(posedge clk);
            #1;
            chk("b2b_ack", {31'h0, s_ack}, 32'h1);
            model_write(2, 4'hF, m_adr, m_dat);
            if (i == 3) begin
                m_cyc = 1'b0;
                m_stb = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("b2b_gap", {31'h0, s_ack}, 32'h0);
        end
        chk("b2b_cnt", {16'h0, s_cnt}, 32'(mcnt[2]));
        xfer(2, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0);
        xfer(2, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
        xfer(2, 1'b0, 4'hF, 32'h0000_0004, 32'h0);
        xfer(2, 1'b0, 4'hF, 32'h0000_0008, 32'h0);
        xfer(2, 1'b0, 4'hF, 32'hFFFF_FFF8, 32'h0);

        // Reset while instance 0 sits in its wait state.
        @(negedge clk);
        cur   = 0;
        m_cyc = 1'b1;
        m_stb = 1'b1;
        m_we  = 1'b1;
        m_sel = 4'hF;
        m_adr = 32'h0000_0014;
        m_dat = 32'h7777_7777;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_ack", {31'h0, wa.o_wbs_ack | wa.o_wbs_err}, 32'h0);
        chk("mid_rst_cnt", {cnt_a, cnt_c}, 32'h0);
        m_cyc = 1'b0;
        m_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        xfer(0, 1'b0, 4'hF, 32'h0000_000C, 32'h0);
        xfer(0, 1'b0, 4'hF, 32'h0000_0014, 32'h0);
        xfer(2, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0);
        xfer(0, 1'b0, 4'hF, 32'h0000_0000, 32'h0);

        // Randomized traffic on all instances.
        for (int n = 0; n < 120; n++) begin
            int d;
            d = n % 3;
            a = base[d] + 32'(4 * $urandom_range(0, rc[d] + 1))
                + 32'($urandom_range(0, 3));
            xfer(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 a, $urandom);
        end
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < rc[d]; i++) begin
                xfer(d, 1'b0, 4'h0, base[d] + 32'(4 * i), 32'h0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
